// File: rtl/logic_arbiter.sv
// Two-requester round-robin front end for a shared logic unit, with a
// 2-entry in-order response FIFO tagging each result with its source and error.
module logic_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [WIDTH-1:0] req0_op1_i,
    input  logic [WIDTH-1:0] req0_op2_i,
    input  logic [8:0]       req0_sel_i,
    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [WIDTH-1:0] req1_op1_i,
    input  logic [WIDTH-1:0] req1_op2_i,
    input  logic [8:0]       req1_sel_i,
    output logic [WIDTH-1:0] lu_op1_o,
    output logic [WIDTH-1:0] lu_op2_o,
    output logic [8:0]       lu_sel_o,
    input  logic [WIDTH-1:0] lu_result_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_data_o,
    output logic             rsp_id_o,
    output logic             rsp_err_o
);

    typedef struct packed {
        logic             id;
        logic             err;
        logic [WIDTH-1:0] data;
    } rsp_t;

    rsp_t       mem [2];
    logic [1:0] count;
    logic       wr_ptr, rd_ptr;
    logic       last_id;
    logic       gnt0, gnt1, can_acc, push, pop, sel_err;
    rsp_t       push_ent, head;

    // last_id resets to 1 so requester 0 wins the first tie
    always_comb begin
        gnt0     = rst_n_i & req0_valid_i & (~req1_valid_i | last_id);
        gnt1     = rst_n_i & req1_valid_i & (~req0_valid_i | ~last_id);
        can_acc  = (count != 2'd2);
        req0_ready_o = gnt0 & can_acc;
        req1_ready_o = gnt1 & can_acc;
        lu_op1_o = '0;
        lu_op2_o = '0;
        lu_sel_o = '0;
        if (gnt1) begin
            lu_op1_o = req1_op1_i;
            lu_op2_o = req1_op2_i;
            lu_sel_o = req1_sel_i;
        end else if (gnt0) begin
            lu_op1_o = req0_op1_i;
            lu_op2_o = req0_op2_i;
            lu_sel_o = req0_sel_i;
        end
        sel_err  = (lu_sel_o == 9'd0) || ((lu_sel_o & (lu_sel_o - 9'd1)) != 9'd0);
        push     = req0_ready_o | req1_ready_o;
        pop      = (count != 2'd0) & rsp_ready_i;
        push_ent.id   = gnt1;
        push_ent.err  = sel_err;
        push_ent.data = sel_err ? '0 : lu_result_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem[0]  <= '0;
            mem[1]  <= '0;
            count   <= 2'd0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            last_id <= 1'b1;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_ent;
                wr_ptr      <= ~wr_ptr;
                last_id     <= gnt1;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_comb begin
        rsp_valid_o = (count != 2'd0);
        head        = rsp_valid_o ? mem[rd_ptr] : '0;
        rsp_data_o  = head.data;
        rsp_id_o    = head.id;
        rsp_err_o   = head.err;
    end

endmodule

// File: doc/logic_arbiter.md
LOGIC_ARBITER -- requirements
Module: logic_arbiter

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits.
REQ-002 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n_i  input  1  reset, asynchronous and active-low.
REQ-004 reqN_valid_i (N=0,1)  input  1  requester N presents an operation; N=0 execute stage, N=1 CSR unit.
REQ-005 reqN_ready_o  output  1  requester N operation accepted this cycle.
REQ-006 reqN_op1_i  input  WIDTH  first operand.
REQ-007 reqN_op2_i  input  WIDTH  second operand or shift amount.
REQ-008 reqN_sel_i  input  9  one-hot select: AND, OR, SLL, SRL, SRA, SLA, XOR, CSR-set, CSR-clear (bit0..bit8).
REQ-009 lu_op1_o  output  WIDTH  operand 1 to the shared logic unit.
REQ-010 lu_op2_o  output  WIDTH  operand 2 to the shared logic unit.
REQ-011 lu_sel_o  output  9  select to the shared logic unit.
REQ-012 lu_result_i  input  WIDTH  combinational result from the shared logic unit.
REQ-013 rsp_valid_o  output  1  response FIFO head valid.
REQ-014 rsp_ready_i  input  1  consumer takes head this cycle.
REQ-015 rsp_data_o  output  WIDTH  head result.
REQ-016 rsp_id_o  output  1  head originating requester.
REQ-017 rsp_err_o  output  1  head request had illegal select.

Function
REQ-018 Response FIFO SHALL be 2 entries deep, in-order; occupancy count 0..2.
REQ-019 Accept SHALL be possible only when count<2 (no push while full, even with same-cycle pop).
REQ-020 Grant: single valid requester wins; both valid -> requester not granted last; last-grant pointer updates only on an accepted request.
REQ-021 reqN_ready_o SHALL be high only for the granted requester while accept is possible; both readies never high together.
REQ-022 lu_op1_o/lu_op2_o/lu_sel_o SHALL combinationally carry the granted requester's fields; all zero when no grant.
REQ-023 On accept (valid&ready) FIFO SHALL push {id, err, data} at that edge, data = lu_result_i.
REQ-024 err SHALL be 1 when sel has zero or more than one bit set; data SHALL then be pushed as 0.
REQ-025 Latency: request accepted at edge k with FIFO empty -> rsp_valid_o high immediately after edge k.
REQ-026 rsp_valid_o = (count!=0); rsp_* outputs reflect head entry; pop on rsp_valid_o&rsp_ready_i.
REQ-027 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-028 rsp_data_o/rsp_id_o/rsp_err_o SHALL be 0 when FIFO empty.
REQ-029 Pop while empty or rsp_ready_i with no valid SHALL have no effect.

Reset
REQ-030 While rst_n_i low: count=0, FIFO entries cleared, pointer set so req0 wins first tie, reqN_ready_o=0, rsp_valid_o=0, rsp_* =0, lu_* =0.
REQ-031 Reset assertion mid-operation SHALL discard all buffered responses immediately; first cycle after release behaves as post-reset.

Verification
REQ-032 req0 AND op1=0xF0F0F0F0 op2=0xFF00FF00, rsp_ready_i=1 -> req0_ready_o=1, next cycle rsp_data_o=0xF000F000, rsp_id_o=0, rsp_err_o=0.
REQ-033 Both valid held 4 cycles (req0 OR, req1 CSR-clear), rsp_ready_i=1 -> grants 0,1,0,1; rsp_id_o sequence 0,1,0,1.
REQ-034 rsp_ready_i=0, req1 issues 3 ops -> first two accepted, req1_ready_o=0 on third while count=2; raise rsp_ready_i -> third accepted one cycle after first pop.
REQ-035 req0 sel=9'b000000011 -> response rsp_err_o=1, rsp_data_o=0; sel=0 same result.
REQ-036 req1 SRA op1=0x80000000 op2=4 -> rsp_data_o=0xF8000000, rsp_id_o=1.
REQ-037 count=2, assert rst_n_i low mid-cycle -> rsp_valid_o falls asynchronously; after release, single req0 op yields exactly one response.
